// File: rtl/pulse_meter_multi.sv
// pulse_meter_multi
//   Multi-channel pulse measurement. Every channel has its own saturating
//   counter that measures high width, low width, period, or rising edges
//   inside a gate window. Each finished measurement is latched and
//   announced with a one-cycle strobe.
//
// Ports
//   sys_clk     system clock, rising edge
//   sys_rst     synchronous active-high reset
//   mode        0 high width, 1 low width, 2 period, 3 gated edge count
//   rst_value   counter start value, shared by all channels
//   ch_en       per-channel enable
//   gate        count window for mode 3
//   sig_in      measured signals, already synchronous
//   sig_out     combinational copy of sig_in
//   meas_data   latched results, channel i at [i*WIDTH +: WIDTH]
//   meas_valid  one-cycle strobe per channel when its result updates
//   meas_ovf    saturation flag latched with each result
module pulse_meter_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [1:0]                mode,
    input  logic [WIDTH-1:0]          rst_value,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      gate,
    input  logic [CHANNELS-1:0]       sig_in,
    output logic [CHANNELS-1:0]       sig_out,
    output logic [CHANNELS*WIDTH-1:0] meas_data,
    output logic [CHANNELS-1:0]       meas_valid,
    output logic [CHANNELS-1:0]       meas_ovf
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic       gate_d;
    logic [1:0] mode_d;
    logic       grise;
    logic       gfall;
    logic       mode_chg;

    assign sig_out  = sig_in;
    assign grise    = gate & ~gate_d;
    assign gfall    = ~gate & gate_d;
    assign mode_chg = (mode != mode_d);

    // Tracking these during reset as well keeps a held gate or mode from
    // looking like an edge or a mode change at reset release.
    always_ff @(posedge sys_clk) begin
        gate_d <= gate;
        mode_d <= mode;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             sig_d;
        logic             sat;
        logic             armed;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] data_r;
        logic             ovf_r;
        logic             valid_r;

        logic             lvl;
        logic             lvl_d;
        logic             rise;
        logic             lvl_rise;
        logic             lvl_fall;
        logic [WIDTH-1:0] cnt_inc;
        logic             sat_inc;

        // Low-width mode is high-width mode on the inverted input.
        assign lvl      = (mode == 2'd1) ? ~sig_in[i] : sig_in[i];
        assign lvl_d    = (mode == 2'd1) ? ~sig_d     : sig_d;
        assign rise     = sig_in[i] & ~sig_d;
        assign lvl_rise = lvl & ~lvl_d;
        assign lvl_fall = ~lvl & lvl_d;

        // Saturating increment: hold at all-ones and flag it.
        assign cnt_inc  = (cnt == '1) ? cnt : cnt + ONE;
        assign sat_inc  = (cnt == '1) ? 1'b1 : sat;

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                sig_d   <= sig_in[i];
                cnt     <= rst_value;
                sat     <= 1'b0;
                armed   <= 1'b0;
                data_r  <= '0;
                ovf_r   <= 1'b0;
                valid_r <= 1'b0;
            end else begin
                sig_d   <= sig_in[i];
                valid_r <= 1'b0;
                if (!ch_en[i] || mode_chg) begin
                    // Disabled channels keep their last result; a mode
                    // change drops any partial count without a strobe.
                    cnt   <= rst_value;
                    sat   <= 1'b0;
                    armed <= 1'b0;
                end else begin
                    case (mode)
                        2'd0, 2'd1: begin
                            if (lvl_rise) begin
                                cnt   <= rst_value + ONE;
                                sat   <= 1'b0;
                                armed <= 1'b1;
                            end else if (lvl && lvl_d) begin
                                cnt <= cnt_inc;
                                sat <= sat_inc;
                            end else if (lvl_fall && armed) begin
                                data_r  <= cnt;
                                ovf_r   <= sat;
                                valid_r <= 1'b1;
                                armed   <= 1'b0;
                            end
                        end
                        2'd2: begin
                            if (rise) begin
                                // Capture the finished period and start the
                                // next one on the same edge.
                                if (armed) begin
                                    data_r  <= cnt;
                                    ovf_r   <= sat;
                                    valid_r <= 1'b1;
                                end
                                cnt   <= rst_value + ONE;
                                sat   <= 1'b0;
                                armed <= 1'b1;
                            end else if (armed) begin
                                cnt <= cnt_inc;
                                sat <= sat_inc;
                            end
                        end
                        default: begin
                            if (grise) begin
                                cnt <= rst_value + {{(WIDTH-1){1'b0}}, rise};
                                sat <= 1'b0;
                            end else if (gate && gate_d) begin
                                if (rise) begin
                                    cnt <= cnt_inc;
                                    sat <= sat_inc;
                                end
                            end else if (gfall) begin
                                // A rise coinciding with the gate fall is
                                // outside the window and is not counted.
                                data_r  <= cnt;
                                ovf_r   <= sat;
                                valid_r <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end

        assign meas_data[i*WIDTH +: WIDTH] = data_r;
        assign meas_valid[i]               = valid_r;
        assign meas_ovf[i]                 = ovf_r;
    end

endmodule

// File: tb/tb_pulse_meter_multi.sv
module tb_pulse_meter_multi;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  mode;
    logic [15:0] rst_value;
    logic [3:0]  ch_en;
    logic        gate;
    logic [3:0]  sig_in;

    logic [3:0]  sig_out;
    logic [63:0] meas_data;
    logic [3:0]  meas_valid;
    logic [3:0]  meas_ovf;

    logic [3:0]  s_sig_out;
    logic [15:0] s_data;
    logic [3:0]  s_valid;
    logic [3:0]  s_ovf;

    int checks = 0;
    int errors = 0;

    pulse_meter_multi #(.WIDTH(16), .CHANNELS(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mode       (mode),
        .rst_value  (rst_value),
        .ch_en      (ch_en),
        .gate       (gate),
        .sig_in     (sig_in),
        .sig_out    (sig_out),
        .meas_data  (meas_data),
        .meas_valid (meas_valid),
        .meas_ovf   (meas_ovf)
    );

    // Narrow instance for saturation behaviour; shares all stimulus.
    pulse_meter_multi #(.WIDTH(4), .CHANNELS(4)) dut_s (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mode       (mode),
        .rst_value  (rst_value[3:0]),
        .ch_en      (ch_en),
        .gate       (gate),
        .sig_in     (sig_in),
        .sig_out    (s_sig_out),
        .meas_data  (s_data),
        .meas_valid (s_valid),
        .meas_ovf   (s_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [15:0] data_of(input int c);
        return meas_data[c*16 +: 16];
    endfunction

    task automatic test_reset();
        sys_rst   = 1'b1;
        mode      = 2'd0;
        rst_value = 16'd0;
        ch_en     = 4'hF;
        gate      = 1'b0;
        sig_in    = 4'b0001;
        repeat (3) tick();
        checks++;
        if (meas_valid !== 4'h0 || meas_data !== 64'h0 || meas_ovf !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0h data=%0h ovf=%0h expected all zero",
                     meas_valid, meas_data, meas_ovf);
        end
        checks++;
        if (s_valid !== 4'h0 || s_data !== 16'h0 || s_ovf !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs_narrow: got valid=%0h data=%0h ovf=%0h expected all zero",
                     s_valid, s_data, s_ovf);
        end
        sig_in = 4'b1010;
        #1;
        checks++;
        if (sig_out !== 4'b1010) begin
            errors++;
            $display("FAIL sig_out_pass: got %0h expected a", sig_out);
        end
        sig_in = 4'b0001;
        #1;
        // ch0 is high across reset release: the fall must not strobe.
        sys_rst = 1'b0;
        repeat (3) tick();
        sig_in = 4'b0000;
        tick();
        checks++;
        if (meas_valid !== 4'h0) begin
            errors++;
            $display("FAIL reset_release_pulse: got valid=%0h expected 0", meas_valid);
        end
        tick();
        checks++;
        if (meas_valid !== 4'h0) begin
            errors++;
            $display("FAIL reset_release_pulse_late: got valid=%0h expected 0", meas_valid);
        end
    endtask

    task automatic test_high_width();
        mode      = 2'd0;
        rst_value = 16'd0;
        sig_in    = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (meas_valid !== 4'h0) begin
                errors++;
                $display("FAIL high_width_early_strobe[%0d]: got valid=%0h expected 0", k, meas_valid);
            end
        end
        sig_in = 4'b0000;
        tick();
        checks++;
        if (meas_valid !== 4'b0001 || data_of(0) !== 16'd5 || meas_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL high_width: got valid=%0h data0=%0d ovf0=%0b expected valid=1 data0=5 ovf0=0",
                     meas_valid, data_of(0), meas_ovf[0]);
        end
        tick();
        checks++;
        if (meas_valid !== 4'h0) begin
            errors++;
            $display("FAIL high_width_strobe_len: got valid=%0h expected 0", meas_valid);
        end
    endtask

    task automatic test_period();
        mode      = 2'd2;
        rst_value = 16'd10;
        sig_in    = 4'b0000;
        repeat (2) tick();
        for (int p = 0; p < 4; p++) begin
            sig_in[1] = 1'b1;
            tick();
            checks++;
            if (p == 0) begin
                if (meas_valid !== 4'h0) begin
                    errors++;
                    $display("FAIL period_first_rise: got valid=%0h expected 0", meas_valid);
                end
            end else begin
                if (meas_valid !== 4'b0010 || data_of(1) !== 16'd17) begin
                    errors++;
                    $display("FAIL period[%0d]: got valid=%0h data1=%0d expected valid=2 data1=17",
                             p, meas_valid, data_of(1));
                end
            end
            repeat (2) tick();
            sig_in[1] = 1'b0;
            repeat (3) tick();
            checks++;
            if (meas_valid !== 4'h0) begin
                errors++;
                $display("FAIL period_idle[%0d]: got valid=%0h expected 0", p, meas_valid);
            end
            tick();
        end
    endtask

    task automatic test_gate_count();
        mode      = 2'd3;
        rst_value = 16'd0;
        gate      = 1'b0;
        sig_in    = 4'b0000;
        repeat (2) tick();
        for (int j = 0; j < 20; j++) begin
            gate      = 1'b1;
            sig_in[2] = (j == 2 || j == 6 || j == 10 || j == 14);
            tick();
        end
        checks++;
        if (meas_valid !== 4'h0) begin
            errors++;
            $display("FAIL gate_open_strobe: got valid=%0h expected 0", meas_valid);
        end
        gate      = 1'b0;
        sig_in[2] = 1'b1;
        tick();
        checks++;
        if (meas_valid !== 4'hF || data_of(2) !== 16'd4 || data_of(1) !== 16'd0) begin
            errors++;
            $display("FAIL gate_count: got valid=%0h data2=%0d data1=%0d expected valid=f data2=4 data1=0",
                     meas_valid, data_of(2), data_of(1));
        end
        sig_in = 4'b0000;
        tick();
        checks++;
        if (meas_valid !== 4'h0) begin
            errors++;
            $display("FAIL gate_after_close: got valid=%0h expected 0", meas_valid);
        end
    endtask

    task automatic test_saturation();
        mode      = 2'd1;
        rst_value = 16'd0;
        sig_in    = 4'b1000;
        repeat (2) tick();
        sig_in[3] = 1'b0;
        repeat (20) tick();
        sig_in[3] = 1'b1;
        tick();
        checks++;
        if (s_valid !== 4'b1000 || s_data[15:12] !== 4'hF || s_ovf[3] !== 1'b1) begin
            errors++;
            $display("FAIL sat_narrow: got valid=%0h data3=%0d ovf3=%0b expected valid=8 data3=15 ovf3=1",
                     s_valid, s_data[15:12], s_ovf[3]);
        end
        checks++;
        if (meas_valid !== 4'b1000 || data_of(3) !== 16'd20 || meas_ovf[3] !== 1'b0) begin
            errors++;
            $display("FAIL low_width_wide: got valid=%0h data3=%0d ovf3=%0b expected valid=8 data3=20 ovf3=0",
                     meas_valid, data_of(3), meas_ovf[3]);
        end
        tick();
        sig_in[3] = 1'b0;
        repeat (3) tick();
        sig_in[3] = 1'b1;
        tick();
        checks++;
        if (s_valid !== 4'b1000 || s_data[15:12] !== 4'd3 || s_ovf[3] !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got valid=%0h data3=%0d ovf3=%0b expected valid=8 data3=3 ovf3=0",
                     s_valid, s_data[15:12], s_ovf[3]);
        end
    endtask

    task automatic test_mode_change();
        mode   = 2'd0;
        sig_in = 4'b0000;
        repeat (2) tick();
        sig_in[0] = 1'b1;
        repeat (3) tick();
        mode = 2'd2;
        repeat (2) tick();
        mode = 2'd0;
        repeat (2) tick();
        sig_in[0] = 1'b0;
        tick();
        checks++;
        if (meas_valid !== 4'h0) begin
            errors++;
            $display("FAIL mode_change_pulse: got valid=%0h expected 0", meas_valid);
        end
        tick();
        sig_in[0] = 1'b1;
        repeat (4) tick();
        sig_in[0] = 1'b0;
        tick();
        checks++;
        if (meas_valid !== 4'b0001 || data_of(0) !== 16'd4) begin
            errors++;
            $display("FAIL mode_change_next: got valid=%0h data0=%0d expected valid=1 data0=4",
                     meas_valid, data_of(0));
        end
    endtask

    task automatic test_back_to_back();
        int w [4] = '{2, 3, 4, 5};
        mode   = 2'd0;
        ch_en  = 4'hF;
        sig_in = 4'b0000;
        tick();
        // Staggered rises, common fall: all four strobe together.
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 4; c++) sig_in[c] = (t >= 5 - w[c]);
            tick();
        end
        sig_in = 4'b0000;
        tick();
        checks++;
        if (meas_valid !== 4'hF) begin
            errors++;
            $display("FAIL simul_valid: got valid=%0h expected f", meas_valid);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (data_of(c) !== 16'(w[c])) begin
                errors++;
                $display("FAIL simul_data[%0d]: got %0d expected %0d", c, data_of(c), w[c]);
            end
        end
        ch_en  = 4'b0111;
        tick();
        sig_in = 4'b1001;
        repeat (3) tick();
        sig_in = 4'b0000;
        tick();
        checks++;
        if (meas_valid !== 4'b0001 || data_of(0) !== 16'd3 || data_of(3) !== 16'd5) begin
            errors++;
            $display("FAIL disabled_ch: got valid=%0h data0=%0d data3=%0d expected valid=1 data0=3 data3=5",
                     meas_valid, data_of(0), data_of(3));
        end
        sig_in[3] = 1'b1;
        repeat (2) tick();
        ch_en = 4'hF;
        repeat (2) tick();
        sig_in = 4'b0000;
        tick();
        checks++;
        if (meas_valid !== 4'h0) begin
            errors++;
            $display("FAIL enable_mid_pulse: got valid=%0h expected 0", meas_valid);
        end
    endtask

    initial begin
        test_reset();
        test_high_width();
        test_period();
        test_gate_count();
        test_saturation();
        test_mode_change();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
